// File: rtl/fetch_queue_pkg.sv
// Shared instruction-fetch types: instruction word type, NOP encoding, PC step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_queue_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int IR_WIDTH    = 32;

  typedef logic [IR_WIDTH-1:0] ir_t;

  // addi x0, x0, 0
  localparam ir_t NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO with push/pop/flush and occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  // Storage array: written on push, no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and count; flush discards everything, including a same-cycle push.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC generation, in-order imem requests, buffered words to decode.
// Latency: response to ir is 1 cycle (0 cycles via bypass when FETCH_QUEUE_BYPASS_EN is defined).
// Backpressure: requests issue only while queue occupancy + in-flight requests < DEPTH; ir held until ir_ready.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] INIT_PC  = PC_WIDTH'(32'h2000)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output ir_t                 ir,
  output logic [PC_WIDTH-1:0] ir_pc,
  output logic                ir_valid,
  input  logic                ir_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INSTR_BYTES);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    ir_t                 ir;
  } fetch_entry_t;

  logic [PC_WIDTH-1:0] pc;          // next address to request
  logic [PC_WIDTH-1:0] resp_pc;     // PC belonging to the next non-discarded response
  logic [CW-1:0]       outstanding; // granted requests not yet answered
  logic [CW-1:0]       discard;     // stale responses still to be dropped

  logic [CW-1:0]       occupancy;
  fetch_entry_t        head;
  fetch_entry_t        push_entry;
  logic                credit, grant, accept, bypass, fifo_empty, push, pop;
  logic [PC_WIDTH-1:0] redirect_aligned;
  logic                unused_redirect_lsbs;

  assign redirect_aligned     = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // In-flight requests reserve queue slots, so an accepted response always fits.
  assign credit    = ({1'b0, occupancy} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
  assign imem_req  = !reset && !redirect && credit;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // A response arriving with a redirect, or while stale ones remain, is dropped.
  assign accept     = imem_rvalid && !redirect && (discard == '0);
  assign fifo_empty = (occupancy == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  // Only an empty queue frees the output; a popping head already owns ir this cycle.
  assign bypass = accept && ir_ready && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push       = accept && !bypass;
  assign pop        = !fifo_empty && ir_ready;
  assign push_entry = '{pc: resp_pc, ir: imem_rdata};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (occupancy)
  );

  // Decode-facing output: queue head, else bypassed response, else NOP.
  always_comb begin
    ir       = NOP;
    ir_pc    = '0;
    ir_valid = 1'b0;
    if (!fifo_empty) begin
      ir       = head.ir;
      ir_pc    = head.pc;
      ir_valid = 1'b1;
    end else if (bypass) begin
      ir       = imem_rdata;
      ir_pc    = resp_pc;
      ir_valid = 1'b1;
    end
  end

  // PC generation and in-flight tracking; a redirect restarts both PC streams.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= INIT_PC;
      resp_pc     <= INIT_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if (redirect) begin
        pc      <= redirect_aligned;
        resp_pc <= redirect_aligned;
        discard <= outstanding - CW'(imem_rvalid);
      end else begin
        if (grant) pc <= pc + PC_STEP;
        if (imem_rvalid) begin
          if (discard != '0) discard <= discard - CW'(1);
          else               resp_pc <= resp_pc + PC_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency instruction memory model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ir_ready = 1'b0;
  logic        imem_req, ir_valid;
  logic [31:0] imem_addr, ir_pc;
  ir_t         ir;

  logic        rst9 = 1'b1;
  logic        gnt9 = 1'b1;
  logic        req9, vld9;
  logic [8:0]  addr9, irpc9;
  ir_t         ir9;

  fetch_queue u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  fetch_queue #(.PC_WIDTH(9), .DEPTH(4), .INIT_PC(9'h1F8)) u_dut9 (
    .clk(clk), .reset(rst9), .imem_req(req9), .imem_addr(addr9),
    .imem_gnt(gnt9), .imem_rvalid(1'b0), .imem_rdata(32'h0),
    .redirect(1'b0), .redirect_pc(9'h0), .ir(ir9), .ir_pc(irpc9),
    .ir_valid(vld9), .ir_ready(1'b0)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;
  int    n_gnt = 0;
  int    n_chk = 0;
  int    n_bad = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Instruction memory: records grants, answers in order after lat cycles, forgets on reset.
  always @(posedge clk) begin
    mreq_t m;
    if (reset) begin
      mq.delete();
      cyc = 0;
    end else begin
      if (imem_req && imem_gnt) begin
        m.addr = imem_addr;
        m.due  = cyc + lat;
        mq.push_back(m);
        n_gnt++;
      end
      if (imem_rvalid) void'(mq.pop_front());
      cyc++;
    end
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Holds reset for a few cycles; returns at the negedge of cycle 0 with reset low.
  task automatic restart(input int l, input logic rdy);
    @(negedge clk);
    reset    = 1'b1;
    redirect = 1'b0;
    ir_ready = rdy;
    lat      = l;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!ir_valid && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_vld", ir_valid, 1);
  endtask

  initial begin
    int g0, n;

    // 1: reset state, then sequential fetch at one instruction per cycle
    ir_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req",   imem_req, 0);
    check("rst_addr",  imem_addr, 32'h2000);
    check("rst_vld",   ir_valid, 0);
    check("rst_ir",    ir, 32'h0000_0013);
    check("rst_irpc",  ir_pc, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t1_req0",  imem_req, 1);
    check("t1_addr0", imem_addr, 32'h2000);
    @(negedge clk); #1;
    check("t1_addr1", imem_addr, 32'h2004);
    check("t1_vld1",  ir_valid, BYP);
    for (int k = 2; k < 10; k++) begin
      @(negedge clk); #1;
      check("t1_vld",  ir_valid, 1);
      check("t1_irpc", ir_pc, 32'h2000 + 4 * (k - 2 + BYP));
      check("t1_ir",   ir, word(32'h2000 + 4 * (k - 2 + BYP)));
      check("t1_addr", imem_addr, 32'h2000 + 4 * k);
    end

    // 2: decode stalled, credits cap grants at DEPTH; one pop frees one request
    restart(1, 1'b0);
    g0 = n_gnt;
    repeat (10) @(negedge clk);
    #1;
    check("t2_grants", n_gnt - g0, 4);
    check("t2_req0",   imem_req, 0);
    check("t2_head",   ir_pc, 32'h2000);
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    #1;
    check("t2_req1",  imem_req, 1);
    check("t2_addr1", imem_addr, 32'h2010);
    check("t2_head1", ir_pc, 32'h2004);
    repeat (4) @(negedge clk);
    #1;
    check("t2_grants1", n_gnt - g0, 5);
    check("t2_req2",    imem_req, 0);

    // 3: latency-3 memory, redirect to an unaligned target while responses are in flight
    restart(3, 1'b1);
    repeat (3) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h3006;
    #1;
    check("t3_rv_at_redir", imem_rvalid, 1);
    check("t3_req_redir",   imem_req, 0);
    check("t3_vld_redir",   ir_valid, 0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t3_addr", imem_addr, 32'h3004);
    check("t3_req",  imem_req, 1);
    check("t3_vld",  ir_valid, 0);
    wait_valid(12, n);
    check("t3_wait", n, 4 - BYP);
    check("t3_irpc", ir_pc, 32'h3004);
    check("t3_ir",   ir, word(32'h3004));

    // 4: redirect coinciding with a response and a pop (latency-2 steady state)
    restart(2, 1'b1);
    repeat (8) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h4000;
    #1;
    check("t4_rv",   imem_rvalid, 1);
    check("t4_vld",  ir_valid, 1 - BYP);
    check("t4_irpc", ir_pc, BYP ? 32'h0 : 32'h2014);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t4_vld_after", ir_valid, 0);
    check("t4_addr",      imem_addr, 32'h4000);
    wait_valid(12, n);
    check("t4_wait", n, 3 - BYP);
    check("t4_irpc1", ir_pc, 32'h4000);

    // 5: 9-bit PC wraps; memory stall holds the request; idle output shows NOP
    @(negedge clk);
    rst9 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("t5_rst_addr", addr9, 9'h1F8);
    check("t5_rst_req",  req9, 0);
    @(negedge clk);
    rst9 = 1'b0;
    #1;
    check("t5_addr0", addr9, 9'h1F8);
    check("t5_req0",  req9, 1);
    @(negedge clk); #1;
    check("t5_addr1", addr9, 9'h1FC);
    @(negedge clk); #1;
    check("t5_addr2", addr9, 9'h000);
    @(negedge clk); #1;
    check("t5_addr3", addr9, 9'h004);
    gnt9 = 1'b0;
    @(negedge clk); #1;
    check("t5_stall_addr", addr9, 9'h004);
    check("t5_stall_req",  req9, 1);
    check("t5_vld",  vld9, 0);
    check("t5_nop",  ir9, 32'h0000_0013);
    check("t5_irpc", irpc9, 0);

    // 6: first response into an empty queue with decode ready
    restart(1, 1'b1);
    @(negedge clk); #1;
    check("t6_rv",    imem_rvalid, 1);
    check("t6_vld",   ir_valid, BYP);
    check("t6_cnt",   u_dut.u_fifo.count, 0);
    @(negedge clk); #1;
    check("t6_cnt1",  u_dut.u_fifo.count, 1 - BYP);
    check("t6_irpc1", ir_pc, 32'h2000 + 4 * BYP);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
